operand_fetch: RTL and testbench

Initiator-side front end for the 32x32 register file. Accepts register-read requests from decode over a valid/ready handshake and drives the file's read and write address ports. Absorbs the file's one-cycle registered-read latency and its read-old-on-same-edge-write behaviour by bypassing and snooping writebacks. Returns both source operands to execute over a second valid/ready handshake, at a throughput of one request per cycle.

---
 rtl/opfetch_pkg.sv | 33 +++
 rtl/opfetch_merge.sv | 34 +++
 rtl/operand_fetch.sv | 198 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opfetch_pkg.sv
// Shared widths, the x0 constant and the lookup-stage entry layout
// for the operand fetch front end.
package opfetch_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int TAGW = 4;

  localparam logic [AW-1:0] REG_X0 = '0;

  // Lookup-stage contents. byp<n> marks a value that came from a writeback
  // (accept-edge bypass or a snoop while stalled). cap marks that byp_data<n>
  // holds the complete operand value because the entry stalled and the
  // registered file read has since moved on to another address.
  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [TAGW-1:0] tag;
    logic            byp1;
    logic            byp2;
    logic [XLEN-1:0] byp_data1;
    logic [XLEN-1:0] byp_data2;
    logic            cap;
  } s1_entry;

  // A writeback that actually reaches the file and targets this register.
  function automatic logic wb_hit(input logic wren, input logic [AW-1:0] rd,
                                  input logic [AW-1:0] rs);
    return wren && (rd == rs);
  endfunction

endpackage

// File: rtl/opfetch_merge.sv
// Per-operand value selection: lookup-to-output transfer value and the
// output-stage snoop value.
module opfetch_merge
  import opfetch_pkg::*;
(
  input  logic [AW-1:0]   s1_rs,
  input  logic [XLEN-1:0] rf_rd,
  input  logic            use_byp,
  input  logic [XLEN-1:0] byp_data,
  input  logic            s1_hit,
  input  logic [AW-1:0]   s2_rs,
  input  logic [XLEN-1:0] s2_data,
  input  logic            s2_hit,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] s1_val,
  output logic [XLEN-1:0] s2_val
);

  // Transfer priority: x0, same-cycle writeback, held bypass, file read.
  always_comb begin
    s1_val = rf_rd;
    if (s1_rs == REG_X0)  s1_val = '0;
    else if (s1_hit)      s1_val = wb_data;
    else if (use_byp)     s1_val = byp_data;
  end

  // Held operand picks up a writeback to its register; x0 stays zero.
  always_comb begin
    s2_val = s2_data;
    if (s2_rs == REG_X0) s2_val = '0;
    else if (s2_hit)     s2_val = wb_data;
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-file read front end: two-stage lookup/output pipe that hides the
// file's registered read and read-old-on-write behaviour by bypass + snoop.
// Optional statistics counters are built when OPFETCH_STATS_EN is defined.
// Note: the S1 entry layout is sized by opfetch_pkg; keep parameters equal
// to the package values.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int XLEN = opfetch_pkg::XLEN,
  parameter int AW   = opfetch_pkg::AW,
  parameter int TAGW = opfetch_pkg::TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  input  logic [TAGW-1:0] req_tag,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   rf_rr1,
  output logic [AW-1:0]   rf_rr2,
  output logic            rf_wren,
  output logic [AW-1:0]   rf_wr,
  output logic [XLEN-1:0] rf_wd,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_rs1_data,
  output logic [XLEN-1:0] op_rs2_data,
  output logic [TAGW-1:0] op_tag
`ifdef OPFETCH_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     byp_cnt
`endif
);

  s1_entry s1_q, s1_d;

  logic            op_valid_q, op_valid_d;
  logic [AW-1:0]   op_rs1_q, op_rs1_d, op_rs2_q, op_rs2_d;
  logic [XLEN-1:0] op_d1_q, op_d1_d, op_d2_q, op_d2_d;
  logic [TAGW-1:0] op_tag_q, op_tag_d;

  logic s2_free, s1_adv, acc;
  logic h1_s1, h2_s1, h1_s2, h2_s2;
  logic [XLEN-1:0] m1_s1, m1_s2, m2_s1, m2_s2;

  // File ports are straight pass-throughs; x0 writes never reach the file.
  assign rf_rr1  = req_rs1;
  assign rf_rr2  = req_rs2;
  assign rf_wren = wb_valid && (wb_rd != REG_X0) && !rst;
  assign rf_wr   = wb_rd;
  assign rf_wd   = wb_data;

  assign s2_free   = !op_valid_q || op_ready;
  assign s1_adv    = s1_q.valid && s2_free;
  assign req_ready = !rst && (!s1_q.valid || s1_adv);
  assign acc       = req_valid && req_ready;

  assign h1_s1 = wb_hit(rf_wren, wb_rd, s1_q.rs1);
  assign h2_s1 = wb_hit(rf_wren, wb_rd, s1_q.rs2);
  assign h1_s2 = wb_hit(rf_wren, wb_rd, op_rs1_q);
  assign h2_s2 = wb_hit(rf_wren, wb_rd, op_rs2_q);

  opfetch_merge u_merge1 (
    .s1_rs(s1_q.rs1), .rf_rd(rf_rd1), .use_byp(s1_q.byp1 | s1_q.cap),
    .byp_data(s1_q.byp_data1), .s1_hit(h1_s1),
    .s2_rs(op_rs1_q), .s2_data(op_d1_q), .s2_hit(h1_s2),
    .wb_data(wb_data), .s1_val(m1_s1), .s2_val(m1_s2)
  );

  opfetch_merge u_merge2 (
    .s1_rs(s1_q.rs2), .rf_rd(rf_rd2), .use_byp(s1_q.byp2 | s1_q.cap),
    .byp_data(s1_q.byp_data2), .s1_hit(h2_s1),
    .s2_rs(op_rs2_q), .s2_data(op_d2_q), .s2_hit(h2_s2),
    .wb_data(wb_data), .s1_val(m2_s1), .s2_val(m2_s2)
  );

  // Lookup stage: capture on accept; if blocked, freeze the resolved value,
  // because the file read data is only valid for one cycle.
  always_comb begin
    s1_d = s1_q;
    if (acc) begin
      s1_d.valid     = 1'b1;
      s1_d.rs1       = req_rs1;
      s1_d.rs2       = req_rs2;
      s1_d.tag       = req_tag;
      s1_d.byp1      = wb_hit(rf_wren, wb_rd, req_rs1);
      s1_d.byp2      = wb_hit(rf_wren, wb_rd, req_rs2);
      s1_d.byp_data1 = wb_data;
      s1_d.byp_data2 = wb_data;
      s1_d.cap       = 1'b0;
    end else if (s1_adv) begin
      s1_d.valid = 1'b0;
    end else if (s1_q.valid) begin
      s1_d.cap       = 1'b1;
      s1_d.byp_data1 = m1_s1;
      s1_d.byp_data2 = m2_s1;
      s1_d.byp1      = s1_q.byp1 || h1_s1;
      s1_d.byp2      = s1_q.byp2 || h2_s1;
    end
  end

  // Output stage: load from lookup, drop on handshake, snoop while held.
  always_comb begin
    op_valid_d = op_valid_q;
    op_rs1_d   = op_rs1_q;
    op_rs2_d   = op_rs2_q;
    op_d1_d    = op_d1_q;
    op_d2_d    = op_d2_q;
    op_tag_d   = op_tag_q;
    if (s1_adv) begin
      op_valid_d = 1'b1;
      op_rs1_d   = s1_q.rs1;
      op_rs2_d   = s1_q.rs2;
      op_d1_d    = m1_s1;
      op_d2_d    = m2_s1;
      op_tag_d   = s1_q.tag;
    end else if (op_valid_q && op_ready) begin
      op_valid_d = 1'b0;
    end else if (op_valid_q) begin
      op_d1_d = m1_s2;
      op_d2_d = m2_s2;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      op_valid_q <= 1'b0;
      op_rs1_q   <= '0;
      op_rs2_q   <= '0;
      op_d1_q    <= '0;
      op_d2_q    <= '0;
      op_tag_q   <= '0;
    end else begin
      s1_q       <= s1_d;
      op_valid_q <= op_valid_d;
      op_rs1_q   <= op_rs1_d;
      op_rs2_q   <= op_rs2_d;
      op_d1_q    <= op_d1_d;
      op_d2_q    <= op_d2_d;
      op_tag_q   <= op_tag_d;
    end
  end

  assign op_valid    = op_valid_q;
  assign op_rs1_data = op_d1_q;
  assign op_rs2_data = op_d2_q;
  assign op_tag      = op_tag_q;

`ifdef OPFETCH_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, byp_cnt_q, byp_cnt_d;
  logic        op_wb1_q, op_wb1_d, op_wb2_q, op_wb2_d;

  // Track per-operand writeback provenance into the output stage, count at handshake.
  always_comb begin
    op_wb1_d    = op_wb1_q;
    op_wb2_d    = op_wb2_q;
    stall_cnt_d = stall_cnt_q + {31'd0, (req_valid && !req_ready)};
    byp_cnt_d   = byp_cnt_q;
    if (op_valid_q && op_ready)
      byp_cnt_d = byp_cnt_q + {31'd0, op_wb1_q} + {31'd0, op_wb2_q};
    if (s1_adv) begin
      op_wb1_d = (s1_q.rs1 != REG_X0) && (h1_s1 || s1_q.byp1);
      op_wb2_d = (s1_q.rs2 != REG_X0) && (h2_s1 || s1_q.byp2);
    end else if (op_valid_q && !op_ready) begin
      op_wb1_d = op_wb1_q || h1_s2;
      op_wb2_d = op_wb2_q || h2_s2;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      byp_cnt_q   <= '0;
      op_wb1_q    <= 1'b0;
      op_wb2_q    <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      byp_cnt_q   <= byp_cnt_d;
      op_wb1_q    <= op_wb1_d;
      op_wb2_q    <= op_wb2_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign byp_cnt   = byp_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus random
// traffic against an architectural register-value model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [4:0]  req_rs1 = '0, req_rs2 = '0;
  logic [3:0]  req_tag = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rf_rr1, rf_rr2, rf_wr;
  logic        rf_wren;
  logic [31:0] rf_wd;
  logic [31:0] rf_rd1 = '0, rf_rd2 = '0;
  logic        op_valid, op_ready = 1'b0;
  logic [31:0] op_rs1_data, op_rs2_data;
  logic [3:0]  op_tag;
`ifdef OPFETCH_STATS_EN
  logic [31:0] stall_cnt, byp_cnt;
`endif

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_wren(rf_wren),
    .rf_wr(rf_wr), .rf_wd(rf_wd), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data), .op_tag(op_tag)
`ifdef OPFETCH_STATS_EN
    , .stall_cnt(stall_cnt), .byp_cnt(byp_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Register file: registered read, returns the old value on a same-edge write.
  logic [31:0] regs [32] = '{default: 32'd0};
  always @(posedge clk) begin
    rf_rd1 <= regs[rf_rr1];
    rf_rd2 <= regs[rf_rr2];
    if (rf_wren) regs[rf_wr] <= rf_wd;
  end

  // Reference model state.
  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] tag;
    int         acc_edge;
  } pend_t;
  pend_t       q[$];
  logic [31:0] arch [32] = '{default: 32'd0};
  int          last_wr [32] = '{default: -1};
  int          cyc = 0, checks = 0, failures = 0;
  int          stall_exp = 0, byp_exp = 0;
  logic        accepted = 1'b0, prev_hold = 1'b0;
  logic [3:0]  prev_tag = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: observe mid-cycle, update model, advance past the edge.
  task automatic step();
    pend_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (rst) begin
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rf_wren", {31'd0, rf_wren}, 32'd0);
      q.delete();
      stall_exp = 0;
      byp_exp   = 0;
      prev_hold = 1'b0;
    end else begin
      chk("rf_wren", {31'd0, rf_wren}, {31'd0, (wb_valid && wb_rd != 5'd0)});
      chk("rf_rr1", {27'd0, rf_rr1}, {27'd0, req_rs1});
      if (prev_hold) begin
        chk("hold_valid", {31'd0, op_valid}, 32'd1);
        chk("hold_tag", {28'd0, op_tag}, {28'd0, prev_tag});
      end
      if (op_valid && op_ready) begin
        checks++;
        assert (q.size() != 0) else begin
          failures++;
          $error("FAIL spurious_op got=tag %h exp=no pending request", op_tag);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("op_tag", {28'd0, op_tag}, {28'd0, e.tag});
          chk("op_rs1", op_rs1_data, arch[e.rs1]);
          chk("op_rs2", op_rs2_data, arch[e.rs2]);
          if (e.rs1 != 0 && last_wr[e.rs1] >= e.acc_edge) byp_exp++;
          if (e.rs2 != 0 && last_wr[e.rs2] >= e.acc_edge) byp_exp++;
        end
      end
      prev_hold = op_valid && !op_ready;
      prev_tag  = op_tag;
      if (req_valid && req_ready) begin
        accepted = 1'b1;
        q.push_back('{rs1: req_rs1, rs2: req_rs2, tag: req_tag, acc_edge: cyc + 1});
      end
      if (req_valid && !req_ready) stall_exp++;
      if (wb_valid && wb_rd != 5'd0) begin
        arch[wb_rd]    = wb_data;
        last_wr[wb_rd] = cyc + 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    wb_valid  = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    op_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    step();
    chk("drain_pending", q.size(), 32'd0);
  endtask

  task automatic check_stats();
`ifdef OPFETCH_STATS_EN
    chk("stall_cnt", stall_cnt, stall_exp);
    chk("byp_cnt", byp_cnt, byp_exp);
`endif
  endtask

  initial begin
    int n;
    logic tog;
    // Reset, with a write and a request presented to prove both are blocked.
    rst = 1'b1; req_valid = 1'b1; req_rs1 = 5'd9; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hDEAD;
    #1;
    step(); step();
    rst = 1'b0; idle();
    #1;
    chk("reset_op_valid", {31'd0, op_valid}, 32'd0);
    chk("reset_op_rs1", op_rs1_data, 32'd0);
    chk("reset_op_rs2", op_rs2_data, 32'd0);
    chk("reset_op_tag", {28'd0, op_tag}, 32'd0);
    check_stats();

    // Plain file read after a prior write; latency check.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234; op_ready = 1'b1;
    step();
    idle();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0; req_tag = 4'd1;
    step();
    chk("lat_accept", {31'd0, accepted}, 32'd1);
    idle();
    chk("lat_not_yet", {31'd0, op_valid}, 32'd0);
    step();
    chk("lat_valid", {31'd0, op_valid}, 32'd1);
    chk("t1_rs1", op_rs1_data, 32'h1234);
    chk("t1_rs2", op_rs2_data, 32'd0);
    step();

    // Request in the same cycle as the writeback of its source.
    req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd5; req_tag = 4'd2;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hAAAA;
    step();
    idle();
    step();
    chk("t2_rs1_accept_byp", op_rs1_data, 32'hAAAA);
    step();

    // Writeback in the lookup cycle.
    req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd3; req_tag = 4'd3;
    step();
    idle();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    step();
    chk("t3_rs2_s1_hit", op_rs2_data, 32'h55);
    idle();
    step();

    // Snoop while the consumer stalls.
    op_ready = 1'b0;
    req_valid = 1'b1; req_rs1 = 5'd4; req_rs2 = 5'd4; req_tag = 4'd4;
    step();
    idle();
    step();
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'd1;
    step();
    wb_data = 32'd2;
    step();
    idle();
    step();
    chk("t4_snoop_rs1", op_rs1_data, 32'd2);
    chk("t4_snoop_rs2", op_rs2_data, 32'd2);
    op_ready = 1'b1;
    step();

    // x0 writes never reach the file and x0 reads as zero.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    #1;
    chk("x0_rf_wren", {31'd0, rf_wren}, 32'd0);
    step();
    idle();
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_tag = 4'd5;
    step();
    idle();
    step();
    chk("x0_read", op_rs1_data, 32'd0);
    drain();
    check_stats();

    // Stream with toggling consumer readiness.
    tog = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_rs1 = 5'($urandom_range(0, 7)); req_rs2 = 5'($urandom_range(0, 7));
      req_tag = i[3:0];
      n = 0;
      do begin
        op_ready = tog; tog = !tog;
        wb_valid = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
        step();
        n++;
      end while (!accepted && n < 20);
      chk("stream_accept", {31'd0, accepted}, 32'd1);
    end
    drain();
    check_stats();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 3) != 0);
      req_rs1   = 5'($urandom_range(0, 7));
      req_rs2   = 5'($urandom_range(0, 7));
      req_tag   = 4'($urandom);
      wb_valid  = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      op_ready  = 1'($urandom_range(0, 2) != 0);
      step();
    end
    drain();
    check_stats();

    // Reset with both stages full discards everything.
    op_ready = 1'b0;
    req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2; req_tag = 4'd9;
    step();
    req_tag = 4'd10;
    step();
    idle();
    step();
    chk("pre_rst_valid", {31'd0, op_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, op_valid}, 32'd0);
    check_stats();
    op_ready = 1'b1;
    step(); step(); step();
    chk("post_rst_valid", {31'd0, op_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
